// File: rtl/coax_buffered_rx.sv
// coax_buffered_rx -- IBM 3270 coax bi-phase receiver with a word FIFO.
//
// Decodes frames from the synchronised line receiver. A frame is at least
// five '1' start bits, a 1.5/1.5-bit low/high code violation, then words of
// {sync=1, data[9:0] MSB first, odd parity}. The frame ends with sync=0,
// one bit time high, then low. Decoded words are buffered in a FIFO that
// the host drains with read_strobe. The first error is held as a sticky
// code that takes over the data output until read_strobe clears it.
//
// Optional feature: define COAX_BUFFERED_RX_PARITY_CHECK_EN to reject words
// with bad parity (ERROR_PARITY). Otherwise the parity bit is ignored.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   rx           in   serial line (asynchronous, synchronised here)
//   read_strobe  in   pop FIFO head, or clear a pending error
//   data[9:0]    out  error ? error code : FIFO head (0 when empty)
//   full         out  FIFO holds DEPTH words
//   empty        out  FIFO holds no words
//   error        out  sticky error flag
//   active       out  receiver is inside a frame
module coax_buffered_rx #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DEPTH          = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       read_strobe,
  output logic [9:0] data,
  output logic       full,
  output logic       empty,
  output logic       error,
  output logic       active
);

  localparam logic [9:0] ERROR_LOSS_OF_MIDBIT_TRANSITION = 10'h001;
  localparam logic [9:0] ERROR_PARITY                    = 10'h002;
  localparam logic [9:0] ERROR_INVALID_END_SEQUENCE      = 10'h004;
  localparam logic [9:0] ERROR_OVERFLOW                  = 10'h008;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(3 * CLOCKS_PER_BIT) + 1;

  typedef logic [TW-1:0] tmr_t;
  // Timing windows in clk cycles, expressed as quarter-bit multiples.
  localparam tmr_t HALF = tmr_t'(CLOCKS_PER_BIT / 2);
  localparam tmr_t T3Q  = tmr_t'((3 * CLOCKS_PER_BIT) / 4);
  localparam tmr_t T5Q  = tmr_t'((5 * CLOCKS_PER_BIT) / 4);
  localparam tmr_t T7Q  = tmr_t'((7 * CLOCKS_PER_BIT) / 4);
  localparam tmr_t T9Q  = tmr_t'((9 * CLOCKS_PER_BIT) / 4);
  localparam tmr_t TMAX = '1;

  typedef enum logic [2:0] {
    IDLE, START_BITS, VIOLATION, SYNC, DATA, END_SEQ
  } state_e;

  // ---------------------------------------------------------------- line sync
  logic rx_meta_q, rx_s_q, rx_prev_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b0;
      rx_s_q    <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  logic edge_w, rise_w, mid_edge;
  assign edge_w = rx_s_q ^ rx_prev_q;
  assign rise_w = edge_w & rx_s_q;

  // ---------------------------------------------------------------- receiver
  state_e     state_q, state_d;
  tmr_t       tmr_q, tmr_d;      // cycles since last mid-bit (reference) edge
  logic [2:0] ones_q, ones_d;
  logic [3:0] bits_q, bits_d;
  logic [9:0] sh_q, sh_d;
  logic       phase_q, phase_d;
  logic       first_q, first_d;  // next word is the first of its frame

  logic       push, pop, err_ev, par_bad;
  logic [9:0] err_code;
  logic       err_q, full_q, empty_q;
  logic [9:0] code_q;

  // Edges arriving before 3/4 of a bit are bit-boundary edges and ignored;
  // only a later edge is the mid-bit transition that carries the bit value.
  assign mid_edge = edge_w && (tmr_q >= T3Q);

`ifdef COAX_BUFFERED_RX_PARITY_CHECK_EN
  assign par_bad = ~(^{sh_q, rx_s_q});
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      ones_q  <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      phase_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ones_q  <= ones_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      phase_q <= phase_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = (tmr_q == TMAX) ? tmr_q : tmr_q + 1'b1;
    ones_d   = ones_q;
    bits_d   = bits_q;
    sh_d     = sh_q;
    phase_d  = phase_q;
    first_d  = first_q;
    push     = 1'b0;
    err_ev   = 1'b0;
    err_code = '0;
    case (state_q)
      IDLE: begin
        // Idle line is low; the first rise is the mid-bit of a start '1'.
        if (rise_w) begin
          state_d = START_BITS;
          tmr_d   = tmr_t'(1);
          ones_d  = 3'd1;
        end
      end
      START_BITS: begin
        if (mid_edge) begin
          tmr_d = tmr_t'(1);
          if (rx_s_q) ones_d = (ones_q == 3'd7) ? ones_q : ones_q + 3'd1;
          else        state_d = IDLE;
        end else if (tmr_q > T5Q) begin
          // Missing mid-bit edge with line low: start of the code violation.
          if (!rx_s_q && ones_q >= 3'd5) begin
            state_d = VIOLATION;
            phase_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      VIOLATION: begin
        if (!phase_q) begin
          // Low ends 2 bits after the last start-bit mid edge.
          if (edge_w) begin
            if (rx_s_q && tmr_q >= T7Q && tmr_q <= T9Q) begin
              phase_d = 1'b1;
              tmr_d   = tmr_t'(1);
            end else begin
              state_d = IDLE;
            end
          end else if (tmr_q > T9Q) begin
            state_d = IDLE;
          end
        end else begin
          // High lasts 1.5 bits; its fall opens the first sync bit, which
          // puts the timer half a bit past a virtual mid-bit edge.
          if (edge_w) begin
            if (!rx_s_q && tmr_q >= T5Q && tmr_q <= T7Q) begin
              state_d = SYNC;
              tmr_d   = HALF + tmr_t'(1);
              first_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (tmr_q > T7Q) begin
            state_d = IDLE;
          end
        end
      end
      SYNC: begin
        if (mid_edge) begin
          tmr_d = tmr_t'(1);
          if (rx_s_q) begin
            state_d = DATA;
            bits_d  = '0;
          end else begin
            state_d = END_SEQ;
            phase_d = 1'b0;
          end
        end else if (tmr_q > T5Q) begin
          err_ev   = 1'b1;
          err_code = ERROR_LOSS_OF_MIDBIT_TRANSITION;
          state_d  = IDLE;
        end
      end
      DATA: begin
        if (mid_edge) begin
          tmr_d = tmr_t'(1);
          if (bits_q == 4'd10) begin
            // rx_s_q is the parity bit; the word commits at its mid-bit.
            first_d = 1'b0;
            state_d = SYNC;
            if (par_bad) begin
              err_ev   = 1'b1;
              err_code = ERROR_PARITY;
              state_d  = IDLE;
            end else if (full_q || (first_q && !empty_q)) begin
              err_ev   = 1'b1;
              err_code = ERROR_OVERFLOW;
              state_d  = IDLE;
            end else begin
              push = 1'b1;
            end
          end else begin
            sh_d   = {sh_q[8:0], rx_s_q};
            bits_d = bits_q + 4'd1;
          end
        end else if (tmr_q > T5Q) begin
          err_ev   = 1'b1;
          err_code = ERROR_LOSS_OF_MIDBIT_TRANSITION;
          state_d  = IDLE;
        end
      end
      END_SEQ: begin
        if (!phase_q) begin
          // Sync-0 ends low; the line must rise at the next boundary.
          if (edge_w) begin
            if (rx_s_q && tmr_q < T3Q) begin
              phase_d = 1'b1;
              tmr_d   = tmr_t'(1);
            end else begin
              err_ev   = 1'b1;
              err_code = ERROR_INVALID_END_SEQUENCE;
              state_d  = IDLE;
            end
          end else if (tmr_q >= T3Q) begin
            err_ev   = 1'b1;
            err_code = ERROR_INVALID_END_SEQUENCE;
            state_d  = IDLE;
          end
        end else begin
          // High for one bit time, then back to idle low.
          if (edge_w) begin
            err_ev   = !(!rx_s_q && tmr_q >= T3Q && tmr_q <= T5Q);
            err_code = err_ev ? ERROR_INVALID_END_SEQUENCE : 10'h000;
            state_d  = IDLE;
          end else if (tmr_q > T5Q) begin
            err_ev   = 1'b1;
            err_code = ERROR_INVALID_END_SEQUENCE;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q  <= 1'b0;
      code_q <= '0;
    end else if (err_q && read_strobe) begin
      err_q  <= 1'b0;
      code_q <= '0;
    end else if (err_ev && !err_q) begin
      err_q  <= 1'b1;
      code_q <= err_code;
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // A strobe while an error is pending only clears the error.
  assign pop   = read_strobe && !err_q && !empty_q;
  assign cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sh_q;
  end

  assign data   = err_q ? code_q : (empty_q ? 10'h000 : mem_q[rd_ptr_q]);
  assign full   = full_q;
  assign empty  = empty_q;
  assign error  = err_q;
  assign active = (state_q != IDLE);

endmodule

// File: tb/tb_coax_buffered_rx.sv
// Bench for coax_buffered_rx: directed frames on the bi-phase line, a
// queue-based model of the FIFO/error behaviour, a per-cycle compare while
// the line is idle, and literal checks that pin the model.
`timescale 1ns/100ps
module tb_coax_buffered_rx;
  localparam int CPB   = 8;
  localparam int DEPTH = 8;
  localparam int HB    = CPB / 2;

  logic       clk = 1'b0, reset_n = 1'b0, rx = 1'b0, read_strobe = 1'b0;
  logic [9:0] data;
  logic       full, empty, error, active;

  coax_buffered_rx #(.CLOCKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .read_strobe(read_strobe),
    .data(data), .full(full), .empty(empty), .error(error), .active(active)
  );

  always #1 clk = ~clk;

  int          vectors = 0, miscompares = 0;
  logic [9:0]  mq[$];
  logic        merr = 1'b0;
  logic [9:0]  mcode = 10'h000;
  logic        busy = 1'b1;
  logic [10:0] frm [16];
  logic [9:0]  rd_val;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [9:0] mdata();
    if (merr) return mcode;
    if (mq.size() != 0) return mq[0];
    return 10'h000;
  endfunction

  task automatic mraise(input logic [9:0] c);
    if (!merr) begin
      merr  = 1'b1;
      mcode = c;
    end
  endtask

  task automatic mframe(input int n);
    bit first;
    int ones;
    first = 1'b1;
    for (int i = 0; i < n; i++) begin
      ones = $countones(frm[i]);
`ifdef COAX_BUFFERED_RX_PARITY_CHECK_EN
      if (ones % 2 == 0) begin
        mraise(10'h002);
        return;
      end
`endif
      if (mq.size() == DEPTH || (first && mq.size() != 0)) begin
        mraise(10'h008);
        return;
      end
      mq.push_back(frm[i][9:0]);
      first = 1'b0;
    end
  endtask

  task automatic mread();
    if (merr) merr = 1'b0;
    else if (mq.size() != 0) void'(mq.pop_front());
  endtask

  function automatic logic [10:0] goodw(input logic [9:0] d);
    return {~^d, d};
  endfunction

  // ---------------------------------------------------------------- compare
  initial begin
    forever begin
      @(negedge clk);
      if (!busy) begin
        chk("data",   data,         mdata());
        chk("full",   10'(full),    10'(mq.size() == DEPTH));
        chk("empty",  10'(empty),   10'(mq.size() == 0));
        chk("error",  10'(error),   10'(merr));
        chk("active", 10'(active),  10'h000);
      end
    end
  end

  // ---------------------------------------------------------------- line
  task automatic hold(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic b);
    hold(~b, HB);
    hold(b, HB);
  endtask

  task automatic preamble();
    for (int i = 0; i < 6; i++) sbit(1'b1);
    hold(1'b0, 3 * HB);
    hold(1'b1, 3 * HB);
  endtask

  task automatic sword(input logic [10:0] pw);
    sbit(1'b1);
    for (int i = 9; i >= 0; i--) sbit(pw[i]);
    sbit(pw[10]);
  endtask

  task automatic send_end();
    sbit(1'b0);
    hold(1'b1, CPB);
    hold(1'b0, 2 * CPB);
  endtask

  task automatic begin_step();
    @(posedge clk);
    busy = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input int n);
    begin_step();
    preamble();
    for (int i = 0; i < n; i++) sword(frm[i]);
    send_end();
    @(posedge clk);
    mframe(n);
    busy = 1'b0;
  endtask

  task automatic do_read();
    begin_step();
    rd_val = data;
    chk("read_data", rd_val, mdata());
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    @(posedge clk);
    mread();
    busy = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_empty",  10'(empty),  10'h001);
    chk("rst_full",   10'(full),   10'h000);
    chk("rst_error",  10'(error),  10'h000);
    chk("rst_data",   data,        10'h000);
    chk("rst_active", 10'(active), 10'h000);
    @(posedge clk);
    busy = 1'b0;
    repeat (4) @(negedge clk);

    // 8-word frame fills the FIFO, then drained in order
    for (int i = 0; i < 8; i++) frm[i] = goodw(10'(i + 1));
    chk("par_pin", {9'h000, frm[2][10]}, 10'h001);
    send_frame(8);
    @(negedge clk);
    chk("f8_full",  10'(full),  10'h001);
    chk("f8_empty", 10'(empty), 10'h000);
    chk("f8_error", 10'(error), 10'h000);
    chk("f8_head",  data,       10'h001);
    for (int i = 0; i < 8; i++) begin
      do_read();
      chk("f8_rd", rd_val, 10'(i + 1));
      repeat (2) @(negedge clk);
    end
    chk("f8_full_end",  10'(full),  10'h000);
    chk("f8_empty_end", 10'(empty), 10'h001);

    // 4-word frame, then a new frame while not empty -> overflow
    for (int i = 0; i < 4; i++) frm[i] = goodw(10'h010 + 10'(i));
    send_frame(4);
    frm[0] = goodw(10'h020);
    send_frame(1);
    @(negedge clk);
    chk("ovf_error", 10'(error), 10'h001);
    chk("ovf_code",  data,       10'h008);
    do_read();
    @(negedge clk);
    chk("ovf_clr_head", data, 10'h010);
    for (int i = 0; i < 4; i++) begin
      do_read();
      chk("ovf_rd", rd_val, 10'h010 + 10'(i));
    end

    // 9 words in one frame -> overflow on the ninth, FIFO stays full
    for (int i = 0; i < 9; i++) frm[i] = {1'b1, 10'h000};
    send_frame(9);
    @(negedge clk);
    chk("f9_error", 10'(error), 10'h001);
    chk("f9_code",  data,       10'h008);
    chk("f9_full",  10'(full),  10'h001);
    chk("f9_empty", 10'(empty), 10'h000);
    do_read();
    for (int i = 0; i < 8; i++) begin
      do_read();
      chk("f9_rd", rd_val, 10'h000);
    end

    // bad parity word
    frm[0] = {1'b1, 10'h001};
    send_frame(1);
    @(negedge clk);
`ifdef COAX_BUFFERED_RX_PARITY_CHECK_EN
    chk("par_error", 10'(error), 10'h001);
    chk("par_code",  data,       10'h002);
    chk("par_empty", 10'(empty), 10'h001);
`else
    chk("par_error", 10'(error), 10'h000);
    chk("par_data",  data,       10'h001);
    chk("par_empty", 10'(empty), 10'h000);
`endif
    do_read();
    @(negedge clk);
    chk("par_clean", 10'(empty), 10'h001);

    // line stuck high mid-word -> loss of mid-bit transition
    begin_step();
    preamble();
    sbit(1'b1); sbit(1'b1); sbit(1'b0); sbit(1'b1);
    hold(1'b1, 3 * CPB);
    hold(1'b0, 2 * CPB);
    @(posedge clk);
    mraise(10'h001);
    busy = 1'b0;
    @(negedge clk);
    chk("lom_error",  10'(error),  10'h001);
    chk("lom_code",   data,        10'h001);
    chk("lom_active", 10'(active), 10'h000);
    do_read();
    @(negedge clk);
    chk("lom_clr", 10'(error), 10'h000);
    frm[0] = goodw(10'h2AA);
    frm[1] = goodw(10'h0F0);
    send_frame(2);
    do_read();
    chk("lom_rd0", rd_val, 10'h2AA);
    do_read();
    chk("lom_rd1", rd_val, 10'h0F0);

    // reset in the middle of a frame
    begin_step();
    preamble();
    sword(goodw(10'h011));
    sword(goodw(10'h012));
    chk("mid_active", 10'(active), 10'h001);
    reset_n = 1'b0;
    rx      = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (16) @(negedge clk);
    @(posedge clk);
    mq.delete();
    merr  = 1'b0;
    busy  = 1'b0;
    @(negedge clk);
    chk("rstm_empty",  10'(empty),  10'h001);
    chk("rstm_error",  10'(error),  10'h000);
    chk("rstm_active", 10'(active), 10'h000);
    frm[0] = goodw(10'h3C5);
    send_frame(1);
    do_read();
    chk("rstm_rd", rd_val, 10'h3C5);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
